// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core sharing a single req/ready memory
// port between instruction fetch and load/store traffic.
module mc_cpu #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [ADDR_W-1:0] dbg_pc
);

    localparam logic [ADDR_W-1:0] PC0 = RESET_PC[ADDR_W-1:0];

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [31:0]       ir, alu_q, mdr;
    logic [31:0]       rf [32];

    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, wb_dst;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_j;
    logic        r_ok, legal, rf_we;
    logic [31:0] rs_v, rt_v, sext, alu_b, alu_y, wb_val;
    logic [31:0] pc4_w, j_tgt_w;
    logic [ADDR_W-1:0] pc4, br_tgt, j_tgt, ea;

    assign op = ir[31:26];
    assign rs = ir[25:21];
    assign rt = ir[20:16];
    assign rd = ir[15:11];
    assign fn = ir[5:0];

    assign is_r    = (op == 6'h00);
    assign is_addi = (op == 6'h08);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);

    assign r_ok = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24)
               || (fn == 6'h25) || (fn == 6'h2A);
    assign legal = is_r ? r_ok
                 : (is_addi | is_lw | is_sw | is_beq | is_j);

    // $0 is never written, so its reset value keeps it reading as zero
    assign rs_v  = rf[rs];
    assign rt_v  = rf[rt];
    assign sext  = {{16{ir[15]}}, ir[15:0]};
    assign alu_b = is_r ? rt_v : sext;

    always_comb begin
        alu_y = rs_v + alu_b;
        if (is_r) begin
            unique case (1'b1)
                fn == 6'h22: alu_y = rs_v - rt_v;
                fn == 6'h24: alu_y = rs_v & rt_v;
                fn == 6'h25: alu_y = rs_v | rt_v;
                fn == 6'h2A: alu_y = {31'b0, $signed(rs_v) < $signed(rt_v)};
                default:     alu_y = rs_v + rt_v;
            endcase
        end
    end

    assign pc4     = pc + ADDR_W'(4);
    assign br_tgt  = pc4 + ADDR_W'({sext[29:0], 2'b00});
    assign pc4_w   = 32'(pc4);
    assign j_tgt_w = {pc4_w[31:28], ir[25:0], 2'b00};
    assign j_tgt   = j_tgt_w[ADDR_W-1:0];
    assign ea      = {alu_q[ADDR_W-1:2], 2'b00};

    assign wb_dst = is_r ? rd : rt;
    assign wb_val = is_lw ? mdr : alu_q;

    assign halted = (state == HALT);
    assign dbg_pc = pc;

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        rf_we     = 1'b0;
        unique case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) state_nx = DECODE;
            end
            DECODE: begin
                if (!legal) begin
                    state_nx = HALT;
                end else if (is_j) begin
                    pc_nx    = j_tgt;
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                if (is_beq) begin
                    pc_nx    = (rs_v == rt_v) ? br_tgt : pc4;
                    retire   = 1'b1;
                    state_nx = FETCH;
                end else if (is_lw || is_sw) begin
                    state_nx = MEM;
                end else begin
                    state_nx = WB;
                end
            end
            MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_sw;
                mem_addr  = ea;
                mem_wdata = rt_v;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_nx    = pc4;
                        retire   = 1'b1;
                        state_nx = FETCH;
                    end else begin
                        state_nx = WB;
                    end
                end
            end
            WB: begin
                rf_we    = 1'b1;
                pc_nx    = pc4;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            HALT: state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= PC0;
            ir    <= '0;
            alu_q <= '0;
            mdr   <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == FETCH && mem_ready) ir <= mem_rdata;
            if (state == EXEC) alu_q <= alu_y;
            if (state == MEM && mem_ready) mdr <= mem_rdata;
            if (rf_we && wb_dst != 5'd0) rf[wb_dst] <= wb_val;
        end
    end

endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: ISA-level reference model feeds retire/store scoreboards;
// a memory responder with configurable wait states serves the core.
module tb_mc_cpu;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req, mem_we, retire, halted;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata, dbg_pc;
    logic [31:0] mem_rdata = 32'h0;

    mc_cpu #(.ADDR_W(32), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retire(retire), .halted(halted), .dbg_pc(dbg_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; int base; int nacc; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;

    ret_t        ret_q[$];
    st_t         st_q[$];
    logic [31:0] mem [1024];
    int          n_cmp = 0, n_bad = 0;
    int          lat_mode = 0;
    bit          exp_halt = 0, halt_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ei(input logic [5:0] op, input int rs,
                                       input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] er(input int rs, input int rt,
                                       input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] ej(input logic [31:0] tgt);
        return {6'h02, tgt[27:2]};
    endfunction

    // ISA interpreter: executes the image and records what must be observed
    task automatic run_model(input int limit);
        logic [31:0] r [32];
        logic [31:0] mm [1024];
        logic [31:0] pc, ins, se, a, v, pc4;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, dst;
        bit          ok, wr;
        ret_q.delete();
        st_q.delete();
        exp_halt = 0;
        for (int i = 0; i < 32; i++) r[i] = 0;
        for (int i = 0; i < 1024; i++) mm[i] = mem[i];
        pc = RPC;
        for (int s = 0; s < limit; s++) begin
            ins = mm[pc[11:2]];
            op = ins[31:26]; fn = ins[5:0];
            rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
            se = {{16{ins[15]}}, ins[15:0]};
            pc4 = pc + 4;
            ok = 1; wr = 0; v = 0; dst = 0;
            case (op)
                6'h00: begin
                    case (fn)
                        6'h20: v = r[rs] + r[rt];
                        6'h22: v = r[rs] - r[rt];
                        6'h24: v = r[rs] & r[rt];
                        6'h25: v = r[rs] | r[rt];
                        6'h2A: v = ($signed(r[rs]) < $signed(r[rt])) ? 1 : 0;
                        default: ok = 0;
                    endcase
                    if (ok) begin
                        wr = 1; dst = rd;
                        ret_q.push_back('{pc, 4, 1}); pc = pc4;
                    end
                end
                6'h08: begin
                    v = r[rs] + se; wr = 1; dst = rt;
                    ret_q.push_back('{pc, 4, 1}); pc = pc4;
                end
                6'h23: begin
                    a = (r[rs] + se) & ~32'h3;
                    v = mm[a[11:2]]; wr = 1; dst = rt;
                    ret_q.push_back('{pc, 5, 2}); pc = pc4;
                end
                6'h2B: begin
                    a = (r[rs] + se) & ~32'h3;
                    mm[a[11:2]] = r[rt];
                    st_q.push_back('{a, r[rt]});
                    ret_q.push_back('{pc, 4, 2}); pc = pc4;
                end
                6'h04: begin
                    ret_q.push_back('{pc, 3, 1});
                    pc = (r[rs] == r[rt]) ? pc4 + (se << 2) : pc4;
                end
                6'h02: begin
                    ret_q.push_back('{pc, 2, 1});
                    pc = {pc4[31:28], ins[25:0], 2'b00};
                end
                default: ok = 0;
            endcase
            if (!ok) begin
                exp_halt = 1;
                break;
            end
            if (wr && dst != 0) r[dst] = v;
        end
    endtask

    task automatic load(input logic [31:0] prog[$]);
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[2] = 32'h5;
        foreach (prog[i]) mem[RPC[11:2] + 10'(i)] = prog[i];
    endtask

    task automatic start_run(input int limit);
        @(negedge clk); #2;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_req", {31'b0, mem_req}, 0);
        chk("rst_we", {31'b0, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_retire", {31'b0, retire}, 0);
        chk("rst_halted", {31'b0, halted}, 0);
        chk("rst_dbg_pc", dbg_pc, RPC);
        run_model(limit);
        @(negedge clk); #2;
        reset = 1'b1;
        #1 chk("req_before_edge", {31'b0, mem_req}, 0);
        @(posedge clk); #1;
        chk("first_req", {31'b0, mem_req}, 1);
        chk("first_addr", mem_addr, RPC);
    endtask

    task automatic finish_run();
        bit done = 0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk); #2;
            done = exp_halt ? halt_seen : (ret_q.size() == 0);
        end
        chk("run_done", {31'b0, done}, 1);
        chk("halted_state", {31'b0, halted}, {31'b0, exp_halt});
        chk("stores_left", 32'(st_q.size()), 0);
        chk("retires_left", 32'(ret_q.size()), 0);
        if (exp_halt) repeat (6) @(negedge clk);
    endtask

    initial begin : responder
        bit          busy;
        int          wcnt;
        logic [31:0] h_addr, h_wdata;
        logic        h_we;
        busy = 0; wcnt = 0;
        h_addr = 0; h_wdata = 0; h_we = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy = 0;
                mem_ready = 1'b0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1;
                    h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
                    case (lat_mode)
                        0: wcnt = 0;
                        1: wcnt = 3;
                        2: wcnt = $urandom_range(0, 3);
                        default: wcnt = (!mem_we && mem_addr == 8) ? 1000000 : 0;
                    endcase
                end else begin
                    chk("hold_addr", mem_addr, h_addr);
                    chk("hold_we", {31'b0, mem_we}, {31'b0, h_we});
                    chk("hold_wdata", mem_wdata, h_wdata);
                end
                if (wcnt == 0) begin
                    mem_ready = 1'b1;
                    busy = 0;
                    if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                    else mem_rdata = mem[mem_addr[11:2]];
                end else begin
                    mem_ready = 1'b0;
                    wcnt--;
                end
            end else begin
                busy = 0;
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    initial begin : monitor
        ret_t        e;
        st_t         s;
        int          eff, raw;
        bit          started, have_last, last_ret;
        logic [31:0] last_pc;
        eff = 0; raw = 0; started = 0;
        have_last = 0; last_ret = 0; last_pc = 0;
        forever begin
            @(negedge clk); #1;
            if (!reset) begin
                started = 0; eff = 0; raw = 0;
                halt_seen = 0; have_last = 0;
            end else begin
                if (have_last && !last_ret) chk("dbg_pc_stable", dbg_pc, last_pc);
                last_pc = dbg_pc; last_ret = retire; have_last = 1;
                if (mem_req) begin
                    started = 1;
                    chk("addr_align", {30'b0, mem_addr[1:0]}, 0);
                end
                if (started) begin
                    raw++;
                    if (!(mem_req && !mem_ready)) eff++;
                end
                if (mem_req && mem_we && mem_ready) begin
                    if (st_q.size() == 0) begin
                        chk("store_unexpected", 32'(st_q.size()), 1);
                    end else begin
                        s = st_q.pop_front();
                        chk("store_addr", mem_addr, s.addr);
                        chk("store_data", mem_wdata, s.data);
                    end
                end
                if (retire) begin
                    if (ret_q.size() == 0) begin
                        chk("retire_unexpected", 32'(ret_q.size()), 1);
                    end else begin
                        e = ret_q.pop_front();
                        chk("retire_pc", dbg_pc, e.pc);
                        chk("cpi", 32'(eff), 32'(e.base));
                        if (lat_mode != 2)
                            chk("cpi_raw", 32'(raw),
                                32'(e.base + ((lat_mode == 1) ? 3 : 0) * e.nacc));
                    end
                    eff = 0; raw = 0;
                end
                if (halted) begin
                    chk("halt_no_req", {31'b0, mem_req}, 0);
                    if (!halt_seen) begin
                        halt_seen = 1;
                        chk("halt_cycles", 32'(eff), 3);
                        chk("halt_expected", {31'b0, exp_halt}, 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] prog[$];
        logic [31:0] ill [3];
        int          n, k, kind;
        bit          seen;
        ill[0] = 32'hFC000000; ill[1] = 32'h00000021; ill[2] = 32'h3C000000;

        // arithmetic sequence, then dump $1..$7
        prog = '{ei(6'h08, 0, 1, 5), ei(6'h08, 0, 2, -7), er(1, 2, 3, 6'h20),
                 er(2, 1, 4, 6'h2A), er(0, 1, 5, 6'h22)};
        for (int r = 1; r < 8; r++) prog.push_back(ei(6'h2B, 0, r, 'hC00 + 4 * r));
        prog.push_back(32'hFC000000);
        lat_mode = 0;
        load(prog); start_run(1000); finish_run();

        // store then load with three wait states on every request
        prog = '{ei(6'h08, 0, 1, 5), ei(6'h2B, 0, 1, 8), ei(6'h23, 0, 6, 8),
                 ei(6'h2B, 0, 6, 'h20), 32'hFC000000};
        lat_mode = 1;
        load(prog); start_run(1000); finish_run();

        // not-taken beq and j back to the start, looping
        prog = '{ei(6'h08, 0, 1, 1), ei(6'h04, 1, 0, 3), ej(32'h100)};
        lat_mode = 0;
        load(prog); start_run(9); finish_run();

        // taken beq onto itself
        prog = '{ei(6'h04, 0, 0, -1)};
        load(prog); start_run(4); finish_run();

        // illegal opcode straight away
        prog = '{32'hFC000000};
        load(prog); start_run(1000); finish_run();

        // reset while a load is stalled in MEM
        prog = '{ei(6'h2B, 0, 6, 'h20), ei(6'h23, 0, 6, 8),
                 ei(6'h2B, 0, 6, 'h24), 32'hFC000000};
        lat_mode = 3;
        load(prog); start_run(1);
        seen = 0; n = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk); #2;
            if (mem_req && !mem_we && mem_addr == 8) n++;
            seen = (n >= 3);
        end
        chk("stall_seen", {31'b0, seen}, 1);
        reset = 1'b0;
        #1 chk("abort_req", {31'b0, mem_req}, 0);
        chk("abort_stores_left", 32'(st_q.size()), 0);
        chk("abort_retires_left", 32'(ret_q.size()), 0);
        lat_mode = 0;
        start_run(1000); finish_run();

        // random forward-only programs
        for (int t = 0; t < 8; t++) begin
            prog.delete();
            n = 24;
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 9);
                k = $urandom_range(0, 2);
                case (kind)
                    0, 1, 2, 3: begin
                        case ($urandom_range(0, 4))
                            0: prog.push_back(er($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h20));
                            1: prog.push_back(er($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h22));
                            2: prog.push_back(er($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h24));
                            3: prog.push_back(er($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h25));
                            default: prog.push_back(er($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 6'h2A));
                        endcase
                    end
                    4, 5: prog.push_back(ei(6'h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535)));
                    6: prog.push_back(ei(6'h2B, 0, $urandom_range(0, 7), 'h800 + $urandom_range(0, 1023)));
                    7: prog.push_back(ei(6'h23, 0, $urandom_range(0, 7), 'h800 + $urandom_range(0, 1023)));
                    8: prog.push_back(ei(6'h04, $urandom_range(0, 3), $urandom_range(0, 3), k));
                    default: prog.push_back(ej(RPC + 32'(4 * (i + 1 + k))));
                endcase
            end
            for (int r = 1; r < 8; r++) prog.push_back(ei(6'h2B, 0, r, 'hC00 + 4 * r));
            prog.push_back(ill[$urandom_range(0, 2)]);
            lat_mode = (t % 3 == 0) ? 0 : 2;
            load(prog); start_run(1000); finish_run();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
